bp_fe_queue_enqueuer: RTL and testbench

//  Frontend-side transmitter of the FE->BE queue protocol. Packs fetched instructions and frontend

---
 rtl/bp_fe_queue_enqueuer_if.sv | 35 +++
 rtl/bp_fe_queue_enqueuer.sv | 104 ++++++++++
 tb/tb_bp_fe_queue_enqueuer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_queue_enqueuer_if.sv
// FE->BE queue enqueuer handshake bundle: fetch and exception inputs, flush, queue output, stall count.
// Exception codes: 0 instr_access_fault, 1 misaligned, 2 page_fault, 3 itlb_miss, 4 icache_miss.
interface bp_fe_queue_enqueuer_if #(
  parameter int unsigned vaddr_width_p               = 39,
  parameter int unsigned branch_metadata_fwd_width_p = 36
);
  localparam int unsigned fe_queue_width_lp = 1 + vaddr_width_p + 32 + branch_metadata_fwd_width_p;

  logic                                   flush_i;
  logic                                   fetch_v_i;
  logic [vaddr_width_p-1:0]               fetch_pc_i;
  logic [31:0]                            fetch_instr_i;
  logic [branch_metadata_fwd_width_p-1:0] fetch_meta_i;
  logic                                   fetch_yumi_o;
  logic                                   exc_v_i;
  logic [vaddr_width_p-1:0]               exc_vaddr_i;
  logic [2:0]                             exc_code_i;
  logic                                   exc_yumi_o;
  logic [fe_queue_width_lp-1:0]           fe_queue_o;
  logic                                   fe_queue_v_o;
  logic                                   fe_queue_ready_i;
  logic [31:0]                            stall_cnt_o;

  modport master (
    input  flush_i, fetch_v_i, fetch_pc_i, fetch_instr_i, fetch_meta_i,
    input  exc_v_i, exc_vaddr_i, exc_code_i, fe_queue_ready_i,
    output fetch_yumi_o, exc_yumi_o, fe_queue_o, fe_queue_v_o, stall_cnt_o
  );

  modport slave (
    output flush_i, fetch_v_i, fetch_pc_i, fetch_instr_i, fetch_meta_i,
    output exc_v_i, exc_vaddr_i, exc_code_i, fe_queue_ready_i,
    input  fetch_yumi_o, exc_yumi_o, fe_queue_o, fe_queue_v_o, stall_cnt_o
  );
endinterface

// File: rtl/bp_fe_queue_enqueuer.sv
// FE->BE queue transmitter: els_p-entry circular buffer plus RUN/HOLD gate after exceptions.
// Optional backpressure counter enabled by BP_FE_QUEUE_STALL_CNT_EN.
module bp_fe_queue_enqueuer #(
  parameter int unsigned vaddr_width_p               = 39,
  parameter int unsigned branch_metadata_fwd_width_p = 36,
  parameter int unsigned els_p                       = 2
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  bp_fe_queue_enqueuer_if.master  fe
);
  localparam int unsigned payload_w_lp = vaddr_width_p + 32 + branch_metadata_fwd_width_p;
  localparam int unsigned msg_w_lp     = 1 + payload_w_lp;
  localparam int unsigned pad_w_lp     = payload_w_lp - vaddr_width_p - 3;
  localparam int unsigned ptr_w_lp     = $clog2(els_p);
  localparam int unsigned cnt_w_lp     = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] els_lp = cnt_w_lp'(els_p);

  typedef enum logic {e_fe_fetch = 1'b0, e_fe_exception = 1'b1} msg_type_e;
  typedef enum logic {RUN, HOLD} state_e;

  state_e                state, state_n;
  logic [ptr_w_lp-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w_lp-1:0]   count;
  logic [msg_w_lp-1:0]   mem [els_p];
  logic [msg_w_lp-1:0]   msg;
  logic                  valid, deq, space, enq;
  logic                  exc_yumi, fetch_yumi;

  assign valid = (count != '0) & ~fe.flush_i;
  assign deq   = valid & fe.fe_queue_ready_i;
  assign space = (count < els_lp) | deq;
  assign enq   = exc_yumi | fetch_yumi;

  // Exception payload sits in the low bits; the remaining union bits are zero.
  always_comb begin
    msg = '0;
    if (fe.exc_v_i) begin
      msg = {e_fe_exception, {pad_w_lp{1'b0}}, fe.exc_vaddr_i, fe.exc_code_i};
    end else begin
      msg = {e_fe_fetch, fe.fetch_pc_i, fe.fetch_instr_i, fe.fetch_meta_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= RUN;
    else            state <= state_n;
  end

  // Yumis are gated by reset so nothing is consumed while the block is held in reset.
  always_comb begin
    state_n    = state;
    exc_yumi   = 1'b0;
    fetch_yumi = 1'b0;
    if ((state == RUN) && reset_n_i && space && !fe.flush_i) begin
      exc_yumi   = fe.exc_v_i;
      fetch_yumi = fe.fetch_v_i & ~fe.exc_v_i;
    end
    if (fe.flush_i)    state_n = RUN;
    else if (exc_yumi) state_n = HOLD;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < els_p; i++) mem[i] <= '0;
    end else if (fe.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= msg;
        wr_ptr      <= wr_ptr + ptr_w_lp'(1);
      end
      if (deq) rd_ptr <= rd_ptr + ptr_w_lp'(1);
      count <= count + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  assign fe.fe_queue_o   = mem[rd_ptr];
  assign fe.fe_queue_v_o = valid;
  assign fe.exc_yumi_o   = exc_yumi;
  assign fe.fetch_yumi_o = fetch_yumi;

`ifdef BP_FE_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Survives flush; only reset clears it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt <= '0;
    end else if (valid && !fe.fe_queue_ready_i && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fe.stall_cnt_o = stall_cnt;
`else
  assign fe.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bp_fe_queue_enqueuer.sv
// Self-checking bench for bp_fe_queue_enqueuer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bp_fe_queue_enqueuer;
  localparam int unsigned V   = 39;
  localparam int unsigned M   = 36;
  localparam int unsigned ELS = 2;
  localparam int unsigned W   = 1 + V + 32 + M;
`ifdef BP_FE_QUEUE_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_fe_queue_enqueuer_if #(.vaddr_width_p(V), .branch_metadata_fwd_width_p(M)) fe_if ();

  bp_fe_queue_enqueuer #(
    .vaddr_width_p(V),
    .branch_metadata_fwd_width_p(M),
    .els_p(ELS)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .fe       (fe_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [W-1:0] q[$];
  bit           hold = 1'b0;
  logic [31:0]  exp_stall = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] fetch_msg(input logic [V-1:0] pc, input logic [31:0] instr,
                                             input logic [M-1:0] meta);
    return {1'b0, pc, instr, meta};
  endfunction

  function automatic logic [W-1:0] exc_msg(input logic [V-1:0] va, input logic [2:0] code);
    logic [W-1:0] m;
    m          = '0;
    m[W-1]     = 1'b1;
    m[V+2:3]   = va;
    m[2:0]     = code;
    return m;
  endfunction

  task automatic drive(input bit fv, input logic [V-1:0] pc, input bit ev, input logic [2:0] code,
                       input logic [V-1:0] va, input bit fl, input bit rdy);
    fe_if.fetch_v_i        = fv;
    fe_if.fetch_pc_i       = pc;
    fe_if.fetch_instr_i    = $urandom();
    fe_if.fetch_meta_i     = M'({$urandom(), $urandom()});
    fe_if.exc_v_i          = ev;
    fe_if.exc_code_i       = code;
    fe_if.exc_vaddr_i      = va;
    fe_if.flush_i          = fl;
    fe_if.fe_queue_ready_i = rdy;
  endtask

  // Called at posedge+1 with inputs driven; checks mid-cycle, then advances the model at the edge.
  task automatic tick();
    bit exp_v, deq, space, ok, ey, fy;
    logic [W-1:0] m;
    #3;
    exp_v = (q.size() != 0) && !fe_if.flush_i;
    deq   = exp_v && fe_if.fe_queue_ready_i;
    space = (q.size() < ELS) || deq;
    ok    = space && !fe_if.flush_i && !hold;
    ey    = fe_if.exc_v_i && ok;
    fy    = fe_if.fetch_v_i && ok && !fe_if.exc_v_i;
    check("fe_queue_v", 128'(fe_if.fe_queue_v_o), 128'(exp_v));
    check("exc_yumi", 128'(fe_if.exc_yumi_o), 128'(ey));
    check("fetch_yumi", 128'(fe_if.fetch_yumi_o), 128'(fy));
    if (exp_v) check("fe_queue_msg", 128'(fe_if.fe_queue_o), 128'(q[0]));
    check("stall_cnt", 128'(fe_if.stall_cnt_o), 128'(exp_stall));
    if (ey)      m = exc_msg(fe_if.exc_vaddr_i, fe_if.exc_code_i);
    else         m = fetch_msg(fe_if.fetch_pc_i, fe_if.fetch_instr_i, fe_if.fetch_meta_i);
    @(posedge clk);
    if (STALL_EN && exp_v && !fe_if.fe_queue_ready_i && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    if (fe_if.flush_i) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (deq) void'(q.pop_front());
      if (ey) begin
        q.push_back(m);
        hold = 1'b1;
      end else if (fy) begin
        q.push_back(m);
      end
    end
    #1;
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst_v", 128'(fe_if.fe_queue_v_o), 128'(0));
    check("rst_fetch_yumi", 128'(fe_if.fetch_yumi_o), 128'(0));
    check("rst_exc_yumi", 128'(fe_if.exc_yumi_o), 128'(0));
    check("rst_msg", 128'(fe_if.fe_queue_o), 128'(0));
    check("rst_stall", 128'(fe_if.stall_cnt_o), 128'(0));
    q.delete();
    hold      = 1'b0;
    exp_stall = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    drive(0, '0, 0, '0, '0, 0, 0);
    #12;
    check("init_v", 128'(fe_if.fe_queue_v_o), 128'(0));
    check("init_msg", 128'(fe_if.fe_queue_o), 128'(0));
    check("init_stall", 128'(fe_if.stall_cnt_o), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single fetch, one-cycle latency to the output
    drive(1, 39'h8000_0000, 0, '0, '0, 0, 1);
    fe_if.fetch_instr_i = 32'h0000_0013;
    tick();
    drive(0, '0, 0, '0, '0, 0, 1);
    repeat (2) tick();

    // Backpressure: third fetch waits for space, order preserved
    for (int i = 1; i <= 3; i++) begin
      drive(1, V'(i), 0, '0, '0, 0, 0);
      tick();
    end
    drive(1, V'(3), 0, '0, '0, 0, 1);
    tick();
    drive(0, '0, 0, '0, '0, 0, 1);
    repeat (3) tick();

    // Exception beats a same-cycle fetch, then HOLD blocks fetches until flush
    drive(1, V'(7), 1, 3'd3, V'(32'h1000), 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, V'(8 + i), 0, '0, '0, 0, 1);
      tick();
    end
    drive(0, '0, 0, '0, '0, 1, 1);
    tick();

    // Flush with a full buffer, then immediate refill
    for (int i = 0; i < 2; i++) begin
      drive(1, V'(16 + i), 0, '0, '0, 0, 0);
      tick();
    end
    drive(1, V'(18), 0, '0, '0, 1, 0);
    tick();
    drive(1, V'(19), 0, '0, '0, 0, 0);
    tick();
    drive(0, '0, 0, '0, '0, 0, 1);
    repeat (2) tick();

    // Full buffer streaming: simultaneous enq/deq across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1, V'(32 + i), 0, '0, '0, 0, 0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, V'(64 + i), 0, '0, '0, 0, 1);
      tick();
    end
    drive(0, '0, 0, '0, '0, 0, 1);
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, V'({$urandom(), $urandom()}), $urandom_range(0, 9) == 0,
            3'($urandom_range(0, 4)), V'({$urandom(), $urandom()}), $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);
      tick();
    end

    // Asynchronous reset mid-stream, stall accumulation, second reset
    drive(1, V'(100), 0, '0, '0, 0, 0);
    tick();
    async_reset_pulse();
    drive(1, V'(101), 0, '0, '0, 0, 0);
    tick();
    drive(0, '0, 0, '0, '0, 0, 0);
    repeat (5) tick();
    check("stall_after_5", 128'(fe_if.stall_cnt_o), STALL_EN ? 128'(5) : 128'(0));
    async_reset_pulse();
    drive(0, '0, 0, '0, '0, 0, 1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
